// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// legal operand-width range.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// One-bit full adder built from two half adders.
// Latency: combinational. Backpressure: none.
// The two partial carries can never both be set.
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic h1_sum;
    logic h1_carry;
    logic h2_carry;

    assign h1_sum   = a ^ b;
    assign h1_carry = a & b;
    assign sum      = h1_sum ^ cin;
    assign h2_carry = h1_sum & cin;
    assign cout     = h1_carry | h2_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Latency: WIDTH+1 cycles from accepted start to done; one result per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             s;
    logic             co;
    logic             last;

    fa_bit_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .sum  (s),
        .cout (co)
    );

    assign last   = (cnt == CNT_W'(WIDTH - 1));
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign s_next = WIDTH'({s, s_sh} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ADD;
            S_ADD:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh <= a_in;
                        b_sh <= b_in;
                        c    <= carry_in;
                        cnt  <= '0;
                        s_sh <= '0;
                    end
                end
                S_ADD: begin
                    c <= co;
                    if (last) begin
                        sum_out   <= s_next;
                        carry_out <= co;
                    end else begin
                        s_sh <= s_next;
                        a_sh <= a_sh >> 1;
                        b_sh <= b_sh >> 1;
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
